// File: rtl/cnn_pkg.sv
// Shared types and sizing constants for the CNN datapath blocks.
package cnn_pkg;

  localparam int DATA_SZ   = 16;
  localparam int ADDR_SZ   = 16;
  localparam int MAX_WORDS = 1024;
  localparam int IDX_W     = $clog2(MAX_WORDS);
  localparam int CNT_W     = $clog2(MAX_WORDS + 1);
  localparam int REQ_W     = 2 * DATA_SZ;

  typedef logic signed [DATA_SZ-1:0] word_t;
  typedef logic        [ADDR_SZ-1:0] addr_t;
  typedef logic        [IDX_W-1:0]   idx_t;
  typedef logic        [CNT_W-1:0]   cnt_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} load_state_t;

  // Oversized requests are clamped to the buffer depth; the caller flags the error.
  function automatic cnt_t clamp_words(input logic [REQ_W-1:0] req);
    if (req > REQ_W'(MAX_WORDS)) begin
      return CNT_W'(MAX_WORDS);
    end
    return CNT_W'(req);
  endfunction

endpackage

// File: rtl/mem_read_pipe.sv
// Tag pipeline that tracks which buffer index each in-flight memory read belongs to.
module mem_read_pipe
  import cnn_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic flush_i,
  input  logic push_valid_i,
  input  idx_t push_tag_i,
  output logic out_valid_o,
  output idx_t out_tag_o,
  output logic busy_o
);

  logic [LAT-1:0] vld_q;
  idx_t           tag_q [LAT];

  always_ff @(posedge clk) begin
    if (!reset || flush_i) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
      vld_q[0] <= push_valid_i;
      tag_q[0] <= push_tag_i;
    end
  end

  assign out_valid_o = vld_q[LAT-1];
  assign out_tag_o   = tag_q[LAT-1];

  // Busy ignores the last stage: its word is captured on the edge that ends the drain.
  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      busy_o = busy_o | vld_q[i];
    end
  end

endmodule

// File: rtl/load_block.sv
// Load stage: streams a loadSize x loadSize image from data memory into a flat buffer.
module load_block
  import cnn_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               loadEnable,
  input  addr_t              loadAddr,
  input  logic [DATA_SZ-1:0] loadSize,
  output addr_t              memAddr,
  output logic               memRead,
  input  word_t              memData,
  output word_t              loadOut [0:MAX_WORDS-1],
  output logic               loadDone,
  output logic               loadError
);

  load_state_t state_q;
  addr_t       addr_q;
  logic        rd_q;
  logic        done_q;
  logic        err_q;
  logic        err_flag_q;
  cnt_t        n_q;
  idx_t        idx_q;
  word_t       buf_q [0:MAX_WORDS-1];

  logic [REQ_W-1:0] req_words;
  cnt_t             n_d;
  logic             err_d;

  logic push_valid;
  logic flush;
  logic cap_valid;
  idx_t cap_tag;
  logic pipe_busy;

  assign req_words = REQ_W'(loadSize) * REQ_W'(loadSize);
  assign err_d     = req_words > REQ_W'(MAX_WORDS);
  assign n_d       = clamp_words(req_words);

  assign push_valid = (state_q == ISSUE) && loadEnable;
  assign flush      = ((state_q == ISSUE) || (state_q == DRAIN)) && !loadEnable;

  mem_read_pipe #(
    .LAT(READ_LAT)
  ) u_pipe (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush),
    .push_valid_i(push_valid),
    .push_tag_i  (idx_q),
    .out_valid_o (cap_valid),
    .out_tag_o   (cap_tag),
    .busy_o      (pipe_busy)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_flag_q <= 1'b0;
      n_q        <= '0;
      idx_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (loadEnable) begin
            n_q        <= n_d;
            err_flag_q <= err_d;
            addr_q     <= loadAddr;
            idx_q      <= '0;
            if (n_d == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= err_d;
            end else begin
              state_q <= ISSUE;
              rd_q    <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (!loadEnable) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
          end else if (cnt_t'(idx_q) == n_q - 1'b1) begin
            state_q <= DRAIN;
            rd_q    <= 1'b0;
          end else begin
            idx_q  <= idx_q + 1'b1;
            addr_q <= addr_q + 1'b1;
          end
        end
        DRAIN: begin
          if (!loadEnable) begin
            state_q <= IDLE;
          end else if (!pipe_busy) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= err_flag_q;
          end
        end
        DONE: begin
          if (!loadEnable) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Capture is driven purely by the tag pipeline, so it runs independently of the FSM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < MAX_WORDS; i++) begin
        buf_q[i] <= '0;
      end
    end else if (cap_valid) begin
      buf_q[cap_tag] <= memData;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < MAX_WORDS; gi++) begin : g_out
      assign loadOut[gi] = buf_q[gi];
    end
  endgenerate

  assign memAddr   = addr_q;
  assign memRead   = rd_q;
  assign loadDone  = done_q;
  assign loadError = err_q;

endmodule
